// File: rtl/ctrl_encode_def_pkg.sv
// ctrl_encode_def_pkg: shared control encodings for the fetch path and next-PC selection
package ctrl_encode_def_pkg;
   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
   localparam logic [2:0]  NPC_PLUS4     = 3'd0;
   localparam logic [2:0]  NPC_BRANCH    = 3'd1;
   localparam logic [2:0]  NPC_JUMP      = 3'd2;
   localparam logic [2:0]  NPC_JALR      = 3'd3;
   typedef enum logic [1:0] {ST_FETCH, ST_HOLD, ST_DRAIN} fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register, flush beats hold beats load
module if_id_reg
   import ctrl_encode_def_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic        i_flush,
   input  logic        i_hold,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_instr,
   output logic [31:0] o_pc,
   output logic [31:0] o_instr,
   output logic        o_valid
);
   // flush inserts a NOP bubble; a held entry keeps its contents
   always_ff @(posedge clk) begin
      if (rst) begin
         o_pc    <= 32'h0;
         o_instr <= NOP_INSTR;
         o_valid <= 1'b0;
      end else if (i_flush) begin
         o_instr <= NOP_INSTR;
         o_valid <= 1'b0;
      end else if (i_load && !i_hold) begin
         o_pc    <= i_pc;
         o_instr <= i_instr;
         o_valid <= 1'b1;
      end
   end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register, fetch FSM, stall hold buffer and redirect drain
module if_fetch_stage
   import ctrl_encode_def_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] npc,
   input  logic        redirect,
   input  logic        stall,
   output logic [31:0] pc_out,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_instr,
   output logic        ifid_valid
);
   fetch_state_e r_state, w_next;
   logic [31:0]  r_pc, r_redir, r_hpc, r_hinstr, w_in_pc, w_in_instr;
   logic         r_pend, w_xfer, w_wait, w_load, w_flush;

   assign pc_out    = r_pc;
   assign imem_addr = r_pc;
   assign w_xfer    = imem_req && imem_ready;
   assign w_wait    = imem_req && !imem_ready;

   // state register
   always_ff @(posedge clk) begin
      r_state <= rst ? ST_FETCH : w_next;
   end

   // next state: an unaccepted request under redirect must drain before the target is fetched
   always_comb begin
      w_next = ST_FETCH;
      case (r_state)
         ST_FETCH: w_next = (redirect && w_wait) ? ST_DRAIN :
                            (!redirect && w_xfer && stall) ? ST_HOLD : ST_FETCH;
         ST_HOLD:  w_next = (redirect || !stall) ? ST_FETCH : ST_HOLD;
         ST_DRAIN: w_next = w_xfer ? ST_FETCH : ST_DRAIN;
         default:  w_next = ST_FETCH;
      endcase
   end

   // outputs: request and IF/ID controls; an outstanding request survives a stall
   always_comb begin
      imem_req   = !rst && ((r_state == ST_DRAIN) || (r_state == ST_FETCH && (!stall || r_pend)));
      w_load     = (r_state == ST_FETCH && w_xfer) || (r_state == ST_HOLD);
      w_flush    = redirect || (r_state == ST_DRAIN) || (r_state == ST_FETCH && !w_xfer && !stall);
      w_in_pc    = (r_state == ST_HOLD) ? r_hpc : r_pc;
      w_in_instr = (r_state == ST_HOLD) ? r_hinstr : imem_rdata;
   end

   // PC, pending flag, redirect target and hold buffer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc     <= RESET_PC;
         r_redir  <= 32'h0;
         r_hpc    <= 32'h0;
         r_hinstr <= 32'h0;
         r_pend   <= 1'b0;
      end else begin
         r_pend <= w_wait;
         if (r_state == ST_FETCH) begin
            if (redirect && w_wait) r_redir <= npc;
            else if (redirect || w_xfer) r_pc <= npc;
            if (!redirect && w_xfer && stall) begin
               r_hpc    <= r_pc;
               r_hinstr <= imem_rdata;
            end
         end
         if (r_state == ST_HOLD && redirect) r_pc <= npc;
         if (r_state == ST_DRAIN) begin
            if (w_xfer) r_pc <= redirect ? npc : r_redir;
            if (redirect) r_redir <= npc;
         end
      end
   end

   if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_flush (w_flush),
      .i_hold  (stall),
      .i_pc    (w_in_pc),
      .i_instr (w_in_instr),
      .o_pc    (ifid_pc),
      .o_instr (ifid_instr),
      .o_valid (ifid_valid)
   );
endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0013 (addi x0,x0,0), instruction presented in IF/ID when empty or flushed.
REQ-003 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1, reset, synchronous and active-high.
REQ-005 Port npc, input, 32, next PC from the next-PC module, which is fed by pc_out.
REQ-006 Port redirect, input, 1, the EX stage has taken a branch, jump or JALR, and npc holds that target.
REQ-007 Port stall, input, 1, the ID stage cannot accept a new IF/ID entry this cycle.
REQ-008 Port pc_out, output, 32, current fetch PC, driving the PC input of the next-PC module.
REQ-009 Port imem_req / imem_addr, output, 1 / 32, instruction-memory request and word address.
REQ-010 Port imem_ready / imem_rdata, input, 1 / 32, request accepted and data valid in the same cycle.
REQ-011 Port ifid_pc / ifid_instr / ifid_valid, output, 32 / 32 / 1, IF/ID pipeline register contents.

Function
REQ-012 A transfer occurs when imem_req and imem_ready are both high; imem_ready without imem_req is ignored.
REQ-013 Once imem_req is asserted, imem_req and imem_addr remain stable until the transfer occurs; a request is never withdrawn.
REQ-014 imem_addr equals pc_q in FETCH and DRAIN, and pc_out equals pc_q at all times.
REQ-015 The state machine has three states: FETCH, HOLD and DRAIN.
REQ-016 FETCH: imem_req is driven high when stall=0 or a request is outstanding (req high and ready low in the previous cycle).
REQ-017 FETCH, transfer, no redirect, no stall: load the IF/ID register with {pc_q, imem_rdata, valid=1} and set pc_q <= npc; latency from transfer to ifid_valid is 1 cycle.
REQ-018 FETCH, transfer, stall=1, no redirect: capture {pc_q, imem_rdata} into the hold buffer, set pc_q <= npc, leave IF/ID unchanged, and go to HOLD.
REQ-019 FETCH, no transfer, stall=0: load a bubble into IF/ID (valid=0, instr=NOP_INSTR).
REQ-020 FETCH, no transfer, stall=1: IF/ID holds its value.
REQ-021 FETCH, redirect with a transfer or with nothing outstanding: set pc_q <= npc, flush IF/ID (valid=0, NOP), discard rdata, and stay in FETCH.
REQ-022 FETCH, redirect while a request is outstanding and not accepted: save npc into redir_q, flush IF/ID, and go to DRAIN.
REQ-023 HOLD: imem_req=0; when stall=0, load IF/ID from the hold buffer (valid=1) and go to FETCH.
REQ-024 HOLD, redirect: discard the hold buffer, set pc_q <= npc, flush IF/ID, and go to FETCH.
REQ-025 DRAIN: keep imem_req=1 with the old address; on transfer, discard rdata, set pc_q <= redir_q, and go to FETCH.
REQ-026 DRAIN, redirect: set redir_q <= npc (the latest redirect wins); IF/ID stays flushed.
REQ-027 Priority: rst over redirect, redirect over stall, and stall over normal advance.
REQ-028 A stop condition (npc == pc_out) refetches the same address each transfer; this is not an error.
REQ-029 PC arithmetic is 32-bit with wrap-around: 32'hFFFF_FFFC followed by +4 gives 32'h0000_0000, with no flag.

Reset
REQ-030 While rst=1 at a rising edge: pc_q=RESET_PC, state=FETCH, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, redir_q=0, hold buffer cleared.
REQ-031 imem_req is 0 during any cycle with rst=1, and any outstanding transfer is abandoned; the memory tolerates abandoned transfers.
REQ-032 Reset asserted mid-DRAIN or mid-HOLD returns the block to FETCH at RESET_PC with no stale data delivered.

Structure
REQ-033 The state encoding, RESET_PC default and NOP_INSTR are defined in the shared ctrl_encode_def definitions alongside the NPC_* opcodes.
REQ-034 The IF/ID register is a sub-module if_id_reg with load, flush and hold controls; PC, the state machine, the hold buffer and redir_q stay in if_fetch_stage.

Verification
REQ-035 Scenario: reset then zero-wait memory, no stall, npc=pc+4 -> imem_addr 0,4,8; ifid_pc 0,4,8 each one cycle later, ifid_valid=1.
REQ-036 Scenario: transfer at pc 0x10 while stall=1 for 3 cycles -> HOLD, imem_req=0, IF/ID unchanged; at stall=0, ifid_pc=0x10 and fetch resumes at 0x14.
REQ-037 Scenario: imem_ready low for 2 cycles at 0x20 and redirect to 0x100 in the first wait cycle -> addr stays 0x20 until ready, data discarded, next addr 0x100, ifid_valid=0 meanwhile.
REQ-038 Scenario: redirect to 0x200 then 0x300 while in DRAIN -> first post-drain fetch at 0x300.
REQ-039 Scenario: redirect and stall together in FETCH with a transfer at 0x40, npc=0x80 -> IF/ID flushed, next addr 0x80, no HOLD entry.
REQ-040 Scenario: rst asserted in HOLD, then pc_q=0xFFFF_FFFC with npc=pc+4 -> after reset, fetch at 0x0; wrap case fetches 0xFFFF_FFFC then 0x0.
